// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: memory geometry, data width
// and the instruction-memory loader state encoding.
package riscv_pkg;

    localparam int IMEM_DEPTH  = 64;
    localparam int IMEM_ADDR_W = 6;
    localparam int XLEN        = 32;

    typedef logic [2:0] ldr_state_t;

    localparam ldr_state_t HDR_LO = 3'd0;
    localparam ldr_state_t HDR_HI = 3'd1;
    localparam ldr_state_t LOAD   = 3'd2;
    localparam ldr_state_t FLUSH  = 3'd3;
    localparam ldr_state_t DONE   = 3'd4;
    localparam ldr_state_t ERR    = 3'd5;

endpackage

// File: rtl/byte_word_packer.sv
// Assembles little-endian bytes into a 32-bit word and pulses
// word_ready_o on the strobe that delivers the fourth byte.
module byte_word_packer
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            clear_i,
    input  logic            strobe_i,
    input  logic [1:0]      byte_idx_i,
    input  logic [7:0]      in_data_i,
    output logic [XLEN-1:0] word_o,
    output logic            word_ready_o
);

    logic [XLEN-1:0] word_q;
    logic [XLEN-1:0] word_d;

    // The completing byte is merged combinationally so the word is
    // whole in the same cycle as word_ready_o.
    always_comb begin
        word_d = word_q;
        if (strobe_i) begin
            word_d[8*byte_idx_i +: 8] = in_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (clear_i) begin
            word_q <= '0;
        end else begin
            word_q <= word_d;
        end
    end

    assign word_o       = word_d;
    assign word_ready_o = strobe_i && (byte_idx_i == 2'd3);

endmodule

// File: rtl/imem_program_loader.sv
// Streams a length-prefixed program into instruction memory and
// holds the core in reset until the last word has been written.
module imem_program_loader
    import riscv_pkg::*;
#(
    parameter int DEPTH  = IMEM_DEPTH,
    parameter int ADDR_W = IMEM_ADDR_W
) (
    input  logic              clk,
    input  logic              areset,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [XLEN-1:0]   imem_wdata,
    output logic              core_run,
    output logic              done,
    output logic              err
);

    ldr_state_t        state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [15:0]       word_cnt_q, word_cnt_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic              in_ready_q, in_ready_d;
    logic              imem_we_q;
    logic [ADDR_W-1:0] imem_addr_q;
    logic [XLEN-1:0]   imem_wdata_q;

    logic              accept;
    logic              pk_strobe;
    logic [XLEN-1:0]   pk_word;
    logic              pk_ready;

    assign accept    = in_valid && in_ready_q;
    assign pk_strobe = accept && (state_q == LOAD);

    byte_word_packer u_packer (
        .clk          (clk),
        .clear_i      (areset),
        .strobe_i     (pk_strobe),
        .byte_idx_i   (byte_idx_q),
        .in_data_i    (in_data),
        .word_o       (pk_word),
        .word_ready_o (pk_ready)
    );

    always_ff @(posedge clk) begin
        if (areset) begin
            state_q    <= HDR_LO;
            len_q      <= '0;
            word_cnt_q <= '0;
            byte_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            word_cnt_q <= word_cnt_d;
            byte_idx_q <= byte_idx_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        word_cnt_d = word_cnt_q;
        byte_idx_d = byte_idx_q;
        unique case (state_q)
            HDR_LO: begin
                if (accept) begin
                    len_d[7:0] = in_data;
                    state_d    = HDR_HI;
                end
            end
            HDR_HI: begin
                if (accept) begin
                    len_d[15:8] = in_data;
                    if (len_d == 16'd0) begin
                        state_d = DONE;
                    end else if (len_d > 16'(DEPTH)) begin
                        state_d = ERR;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                if (accept) begin
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (pk_ready) begin
                        word_cnt_d = word_cnt_q + 16'd1;
                        if (word_cnt_q == len_q - 16'd1) begin
                            state_d = FLUSH;
                        end
                    end
                end
            end
            FLUSH:   state_d = DONE;
            default: state_d = state_q;
        endcase
    end

    // Registered ready keeps in_ready low in the cycle after reset.
    always_comb begin
        in_ready_d = (state_d == HDR_LO) || (state_d == HDR_HI) ||
                     (state_d == LOAD);
    end

    always_ff @(posedge clk) begin
        if (areset) begin
            in_ready_q   <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
        end else begin
            in_ready_q <= in_ready_d;
            imem_we_q  <= pk_ready;
            if (pk_ready) begin
                imem_addr_q  <= word_cnt_q[ADDR_W-1:0];
                imem_wdata_q <= pk_word;
            end
        end
    end

    always_comb begin
        in_ready   = in_ready_q;
        imem_we    = imem_we_q;
        imem_addr  = imem_addr_q;
        imem_wdata = imem_wdata_q;
        done       = (state_q == DONE);
        core_run   = (state_q == DONE);
        err        = (state_q == ERR);
    end

endmodule

// File: tb/tb_imem_program_loader.sv
// Directed bench for the instruction-memory program loader.
module tb_imem_program_loader;

    logic        clk = 1'b0;
    logic        areset = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        imem_we;
    logic [5:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        core_run;
    logic        done;
    logic        err;

    int checks = 0;
    int errors = 0;

    logic [5:0]  wr_addr[$];
    logic [31:0] wr_data[$];
    logic [5:0]  sav_addr;
    logic [31:0] sav_data;

    always #5 clk = ~clk;

    imem_program_loader dut (
        .clk        (clk),
        .areset     (areset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_run   (core_run),
        .done       (done),
        .err        (err)
    );

    always @(negedge clk) begin
        if (imem_we) begin
            wr_addr.push_back(imem_addr);
            wr_data.push_back(imem_wdata);
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        areset   = 1'b1;
        in_valid = 1'b0;
        tick();
        areset = 1'b0;
    endtask

    // Presents one byte and returns #1 after the edge that took it.
    task automatic send(input logic [7:0] b);
        logic ok;
        int   n;
        in_valid = 1'b1;
        in_data  = b;
        n  = 0;
        ok = 1'b0;
        while (!ok && n < 50) begin
            @(negedge clk);
            ok = in_ready;
            tick();
            n++;
        end
        if (!ok) check("send_timeout", 32'(b), 32'hFFFF_FFFF);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
    endtask

    initial begin
        // Reset state
        do_reset();
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_we", 32'(imem_we), 0);
        check("rst_done", 32'(done), 0);
        check("rst_run", 32'(core_run), 0);
        check("rst_err", 32'(err), 0);
        tick();
        check("rdy_after_rst", 32'(in_ready), 1);

        // 1: two-word program, back-to-back
        clear_log();
        send(8'h02); send(8'h00);
        send(8'h13); send(8'h05); send(8'hA0); send(8'h00);
        send(8'h93); send(8'h05); send(8'hB0);
        send(8'h00);
        in_valid = 1'b0;
        check("t1_we_last", 32'(imem_we), 1);
        check("t1_done_early", 32'(done), 0);
        tick();
        check("t1_done", 32'(done), 1);
        check("t1_run", 32'(core_run), 1);
        check("t1_in_ready", 32'(in_ready), 0);
        idle(2);
        check("t1_nwr", wr_addr.size(), 2);
        if (wr_addr.size() == 2) begin
            check("t1_a0", 32'(wr_addr[0]), 0);
            check("t1_d0", wr_data[0], 32'h00A0_0513);
            check("t1_a1", 32'(wr_addr[1]), 1);
            check("t1_d1", wr_data[1], 32'h00B0_0593);
        end

        // 2: zero-length header
        do_reset(); tick(); clear_log();
        send(8'h00); send(8'h00);
        in_valid = 1'b0;
        check("t2_done", 32'(done), 1);
        check("t2_run", 32'(core_run), 1);
        idle(3);
        check("t2_nwr", wr_addr.size(), 0);

        // 3: oversize header
        do_reset(); tick(); clear_log();
        send(8'h41); send(8'h00);
        check("t3_err", 32'(err), 1);
        in_data = 8'h55;
        tick();
        check("t3_in_ready", 32'(in_ready), 0);
        tick(); tick();
        check("t3_run", 32'(core_run), 0);
        check("t3_nwr", wr_addr.size(), 0);
        do_reset();
        check("t3_err_clr", 32'(err), 0);
        tick();

        // 4: gap in the byte stream mid-word
        clear_log();
        send(8'h01); send(8'h00);
        send(8'hEF); send(8'hBE);
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t4_gap_we", 32'(imem_we), 0);
        end
        check("t4_idx", 32'(dut.byte_idx_q), 2);
        send(8'hAD); send(8'hDE);
        in_valid = 1'b0;
        idle(3);
        check("t4_done", 32'(done), 1);
        check("t4_nwr", wr_addr.size(), 1);
        if (wr_addr.size() == 1) begin
            check("t4_a0", 32'(wr_addr[0]), 0);
            check("t4_d0", wr_data[0], 32'hDEAD_BEEF);
        end

        // 5: reset mid-load, reset coinciding with a presented byte
        do_reset(); tick(); clear_log();
        send(8'h03); send(8'h00);
        send(8'h11); send(8'h12); send(8'h13); send(8'h14);
        send(8'h15); send(8'h16);
        in_data  = 8'h17;
        areset   = 1'b1;
        tick();
        areset = 1'b0;
        in_valid = 1'b0;
        check("t5_rst_done", 32'(done), 0);
        check("t5_rst_idx", 32'(dut.byte_idx_q), 0);
        tick();
        send(8'h01); send(8'h00);
        send(8'h78); send(8'h56); send(8'h34); send(8'h12);
        in_valid = 1'b0;
        idle(3);
        check("t5_done", 32'(done), 1);
        check("t5_nwr", wr_addr.size(), 2);
        if (wr_addr.size() == 2) begin
            check("t5_d0", wr_data[0], 32'h1413_1211);
            check("t5_a1", 32'(wr_addr[1]), 0);
            check("t5_d1", wr_data[1], 32'h1234_5678);
        end

        // 6: bytes after DONE are ignored
        clear_log();
        sav_addr = imem_addr;
        sav_data = imem_wdata;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_data = 8'(8'hA0 + i);
            tick();
            check("t6_in_ready", 32'(in_ready), 0);
        end
        in_valid = 1'b0;
        tick();
        check("t6_nwr", wr_addr.size(), 0);
        check("t6_done", 32'(done), 1);
        check("t6_addr", 32'(imem_addr), 32'(sav_addr));
        check("t6_data", imem_wdata, sav_data);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
